// File: rtl/stream_demux_1_4.sv
// Stream 1:4 demultiplexer: routes each valid/ready packet to one of four channels,
// locking the channel chosen on the first beat until the last beat.
module stream_demux_1_4 #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_last,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [3:0]       out_last,
    output logic             sel_err
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e           state_q;
    logic [1:0]       lock_ch_q;
    logic [3:0]       valid_q;
    logic [3:0]       valid_d;
    logic [3:0]       last_q;
    logic [WIDTH-1:0] data_q [4];
    logic             sel_err_q;
    logic [1:0]       target;
    logic             accept;

    always_comb begin
        target   = (state_q == StLocked) ? lock_ch_q : in_sel;
        in_ready = !valid_q[target] || out_ready[target];
        accept   = in_valid && in_ready;
        // Drain first, then a load into the same slot keeps it valid.
        valid_d  = valid_q & ~out_ready;
        if (accept) begin
            valid_d[target] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            lock_ch_q <= 2'd0;
            valid_q   <= 4'd0;
            last_q    <= 4'd0;
            sel_err_q <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            sel_err_q <= 1'b0;
            if (accept) begin
                data_q[target] <= in_data;
                last_q[target] <= in_last;
                unique case (state_q)
                    StIdle: begin
                        if (!in_last) begin
                            lock_ch_q <= in_sel;
                            state_q   <= StLocked;
                        end
                    end
                    StLocked: begin
                        sel_err_q <= (in_sel != lock_ch_q);
                        if (in_last) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_stream_demux_1_4.sv
// Self-checking bench for stream_demux_1_4: directed scenarios plus random traffic
// checked every cycle against a packet-level model and per-channel delivery queues.
module tb_stream_demux_1_4;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid, in_ready, in_last, sel_err;
    logic [W-1:0] in_data;
    logic [1:0]   in_sel;
    logic [3:0]   out_valid, out_ready, out_last;
    logic [W-1:0] out_data0, out_data1, out_data2, out_data3;

    stream_demux_1_4 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .out_last  (out_last),
        .sel_err   (sel_err)
    );

    always #5 clk = ~clk;

    // Model: slot contents, packet ownership, and beats delivered but not yet taken.
    bit   [3:0]   mv, ml;
    logic [W-1:0] md [4];
    bit           open;
    bit   [1:0]   och;
    bit           merr;
    logic [W:0]   sent [4][$];
    int           total, bad, err_seen;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] get_data(input int k);
        case (k)
            0:       return out_data0;
            1:       return out_data1;
            2:       return out_data2;
            default: return out_data3;
        endcase
    endfunction

    task automatic model_reset();
        mv = '0; ml = '0; open = 0; och = '0; merr = 0;
        for (int k = 0; k < 4; k++) begin
            md[k] = '0;
            sent[k].delete();
        end
    endtask

    // One clock: drive, check in_ready and consumer handshakes, step model, check outputs.
    task automatic cycle(input bit iv, input bit [1:0] sel, input logic [W-1:0] d,
                         input bit last, input bit [3:0] ordy, output bit acc);
        bit [1:0]   t;
        bit         exp_rdy;
        logic [W:0] f;
        in_valid = iv; in_sel = sel; in_data = d; in_last = last; out_ready = ordy;
        #1;
        t       = open ? och : sel;
        exp_rdy = !mv[t] || ordy[t];
        chk("in_ready", in_ready, exp_rdy);
        acc = iv && exp_rdy;
        for (int k = 0; k < 4; k++) begin
            if (out_valid[k] && out_ready[k]) begin
                chk("sb_depth", sent[k].size(), 1);
                if (sent[k].size() != 0) begin
                    f = sent[k].pop_front();
                    chk("sb_beat", {out_last[k], get_data(k)}, f);
                end
            end
        end
        merr = acc && open && (sel != och);
        for (int k = 0; k < 4; k++) if (mv[k] && ordy[k]) mv[k] = 0;
        if (acc) begin
            mv[t] = 1; md[t] = d; ml[t] = last;
            sent[t].push_back({last, d});
            if (!open && !last) begin
                open = 1; och = sel;
            end else if (open && last) begin
                open = 0;
            end
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, mv);
        chk("out_last", out_last, ml);
        for (int k = 0; k < 4; k++) chk("out_data", get_data(k), md[k]);
        chk("sel_err", sel_err, merr);
        if (sel_err) err_seen++;
    endtask

    initial begin
        bit           acc, pend, p_last;
        bit   [1:0]   p_sel;
        logic [W-1:0] p_data;
        total = 0; bad = 0; err_seen = 0;
        in_valid = 0; in_sel = 0; in_data = 0; in_last = 0; out_ready = 0;
        model_reset();
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_err", sel_err, 0);
        chk("rst_data0", out_data0, 0);
        chk("rst_ready", in_ready, 1);
        rst_n = 1;

        // Single-beat routing
        for (int i = 0; i < 4; i++) begin
            cycle(1, 2'(i), W'(10 + i), 1, 4'hf, acc);
            chk("route_valid", out_valid, 32'(1 << i));
            chk("route_data", get_data(i), 10 + i);
        end
        cycle(0, 0, 0, 0, 4'hf, acc);

        // Packet lock with mismatching in_sel on beats 2 and 3
        err_seen = 0;
        cycle(1, 2, 1, 0, 4'hf, acc);
        cycle(1, 0, 2, 0, 4'hf, acc);
        cycle(1, 0, 3, 1, 4'hf, acc);
        cycle(0, 0, 0, 0, 4'hf, acc);
        chk("lock_err_count", err_seen, 2);
        chk("lock_data2", out_data2, 3);
        chk("lock_ch0_kept", out_data0, 4'ha);

        // Backpressure on channel 1
        cycle(1, 1, 4, 1, 4'b1101, acc);
        chk("bp_first", out_data1, 4);
        cycle(1, 1, 5, 1, 4'b1101, acc);
        chk("bp_stall1", in_ready, 0);
        cycle(1, 1, 5, 1, 4'b1101, acc);
        chk("bp_stall2", in_ready, 0);
        cycle(1, 1, 5, 1, 4'hf, acc);
        chk("bp_second", out_data1, 5);
        chk("bp_valid", out_valid[1], 1);
        cycle(0, 0, 0, 0, 4'hf, acc);

        // Simultaneous take and load on channel 3
        cycle(1, 3, 4, 1, 4'b0111, acc);
        for (int v = 5; v <= 8; v++) begin
            cycle(1, 3, W'(v), 1, 4'hf, acc);
            chk("tl_valid", out_valid[3], 1);
            chk("tl_data", out_data3, v);
        end
        cycle(0, 0, 0, 0, 4'hf, acc);

        // Independent drain of channels 0/1 while streaming to channel 2
        cycle(1, 0, 1, 1, 4'b1100, acc);
        cycle(1, 1, 2, 1, 4'b1100, acc);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 2, W'(i + 6), 1, (i < 2) ? 4'b1100 : 4'hf, acc);
            chk("drain_ch2", out_data2, i + 6);
        end
        chk("drain_01", out_valid[1:0], 0);

        // Reset mid-packet
        cycle(1, 1, 1, 0, 4'hf, acc);
        cycle(1, 1, 2, 0, 4'hf, acc);
        rst_n = 0;
        #1;
        model_reset();
        chk("midrst_valid", out_valid, 0);
        chk("midrst_err", sel_err, 0);
        #2;
        rst_n = 1; in_valid = 0;
        cycle(1, 3, 9, 1, 4'hf, acc);
        chk("midrst_ch3", out_data3, 9);
        chk("midrst_valid3", out_valid, 4'b1000);

        // Random traffic; an offered beat is held until accepted
        pend = 0; p_sel = 0; p_data = 0; p_last = 0;
        for (int n = 0; n < 800; n++) begin
            if (!pend && $urandom_range(0, 3) != 0) begin
                pend   = 1;
                p_data = W'($urandom);
                p_last = ($urandom_range(0, 2) == 0);
                p_sel  = 2'($urandom);
            end
            cycle(pend, pend ? p_sel : 2'($urandom), p_data, p_last, 4'($urandom), acc);
            if (acc) pend = 0;
        end
        for (int n = 0; n < 3; n++) cycle(0, 0, 0, 0, 4'hf, acc);
        for (int k = 0; k < 4; k++) chk("final_empty", sent[k].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_demux_1_4.md
# stream_demux_1_4

Stream-level 1:4 demultiplexer: the distributing counterpart of the 4:1 gate-level mux. It accepts one valid/ready input stream of WIDTH-bit beats and routes each packet to one of four valid/ready output channels. The channel is chosen by `in_sel` on the first beat of the packet and locked until the beat with `in_last`. Each channel has a one-entry output register. The block sits between a single producer and four independent consumers, for example the four data sources feeding a downstream `mux_4_1`.

## Interface
- `WIDTH`, default 4: beat data width in bits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  input beat present.
- `in_ready`  out  1  input beat accepted this cycle when high together with `in_valid`.
- `in_data`  in  WIDTH  input beat payload.
- `in_sel`  in  2  target channel; sampled only on the first beat of a packet.
- `in_last`  in  1  final beat of the packet.
- `out_valid`  out  4  bit k high means channel k holds a beat.
- `out_ready`  in  4  bit k high means channel k consumer takes the beat.
- `out_data0` .. `out_data3`  out  WIDTH each  channel payload registers.
- `out_last`  out  4  bit k is the last flag of the beat held in channel k.
- `sel_err`  out  1  one-cycle pulse: `in_sel` differed from the locked channel on an accepted non-first beat.

## Operation
State machine with two states:
- **IDLE**: no packet open. The target channel is `in_sel`.
  - An accepted beat with `in_last`=0 latches `in_sel` into `lock_ch` and moves to LOCKED.
  - An accepted beat with `in_last`=1 is a single-beat packet; stay in IDLE.
- **LOCKED**: the target channel is `lock_ch`, and `in_sel` is ignored for routing.
  - An accepted beat with `in_last`=1 returns to IDLE.
  - On an accepted beat with `in_sel` != `lock_ch`, `sel_err` pulses high in the following cycle. The beat still goes to `lock_ch`.

Channel slot k (valid bit, data, last):
- `in_ready` = !`out_valid[t]` | `out_ready[t]`, where t is the current target. It is combinational and depends only on channel t.
- On acceptance, slot t loads `in_data` and `in_last` and sets its valid bit.
- If `out_valid[k]` and `out_ready[k]` are high and no new beat loads slot k, the valid bit clears.
- When a beat is taken out and a new beat is loaded in the same cycle, the slot stays valid with the new data. This gives full throughput.
- Non-target channels drain independently of input traffic.
- `out_data`/`out_last` hold their last loaded value while invalid.
- `out_valid[k]` never drops without handshake k.

Reset values: state IDLE, `lock_ch`=0, `out_valid`=0, `out_last`=0, all `out_data`=0, `sel_err`=0.

## Timing
- Latency: a beat accepted at edge N is visible on channel t with `out_valid` high after edge N.
- Throughput: one beat per cycle while the target consumer holds `out_ready` high.
- Backpressure: if the target slot is full and its `out_ready` is low, `in_ready` stays low. Beats for other channels cannot bypass, because a packet owns the input.
- `in_sel` and `in_last` are only meaningful when `in_valid` is high. With `in_valid` low, no state changes except drains.
- In IDLE, `in_ready` follows `in_sel` combinationally, and the producer must hold `in_sel` stable while `in_valid` is high.
- Reset asserted mid-packet:
  - Immediately clears all slots and returns to IDLE.
  - Any partial packet is dropped.
  - The next accepted beat after release is treated as a first beat.
- `sel_err` is registered and lasts one cycle per offending beat.

## Test plan
- **Single-beat routing.** Send beats 'ha/'hb/'hc/'hd, all with `in_last`=1, `in_sel`=0,1,2,3, and `out_ready`=4'hf. Expect each value on `out_data0`..`out_data3` one cycle after acceptance, with `out_valid` showing one bit per cycle and `in_ready` constant 1.
- **Packet lock.** Send a packet on `in_sel`=2 of beats 1,2,3 (last on 3), with `in_sel` driven to 0 on beats 2 and 3. Expect all beats on channel 2 only, `sel_err` high for two cycles, and channel 0 untouched.
- **Backpressure.** Hold `out_ready[1]`=0 and send two beats to channel 1. Expect the first held in the slot, `in_ready`=0 for the second until `out_ready[1]` rises, then the second appears the cycle after.
- **Simultaneous take and load.** With channel 3 full and `out_ready[3]`=1, send a beat each cycle for 4 cycles (values 5,6,7,8). Expect `out_valid[3]` continuously high and data sequence 5,6,7,8 with no bubble.
- **Independent drain.** Fill channels 0 and 1, then stream to channel 2 while releasing `out_ready[0]` and `out_ready[1]`. Expect channels 0 and 1 to drain with no effect on channel 2 timing.
- **Reset mid-packet.** Assert `rst_n`=0 after beat 2 of a 4-beat packet on channel 1. Expect `out_valid`=0 and `sel_err`=0. Then send a single beat with `in_sel`=3 and expect it on channel 3.
